// File: rtl/fir_xifu_wb.sv
// FIR XIFU writeback stage. It is the only writer of the XIFU regfile, and it
// returns one CV-X-IF result per instruction through a small in-order FIFO.
package fir_xifu_pkg;

    localparam int unsigned XIFU_NB_REGS = 4;
    localparam int unsigned XIFU_RD_W    = $clog2(XIFU_NB_REGS);

    typedef struct packed {
        logic                 write;
        logic [XIFU_RD_W-1:0] rd;
        logic [31:0]          result;
    } fir_xifu_wb2regfile_t;

endpackage

module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int unsigned NB_REGS    = XIFU_NB_REGS,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [X_ID_WIDTH-1:0]      ex_id_i,
    input  logic [31:0]                ex_result_i,
    input  logic [$clog2(NB_REGS)-1:0] ex_xrd_i,
    input  logic                       ex_xwe_i,
    input  logic [4:0]                 ex_crd_i,
    input  logic                       ex_cwe_i,

    output fir_xifu_wb2regfile_t       wb2regfile_o,

    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [31:0]                result_data_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o
);

    localparam int unsigned RD_W  = $clog2(NB_REGS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Stage register
    logic                  r_valid;
    logic [X_ID_WIDTH-1:0] r_id;
    logic [31:0]           r_result;
    logic [RD_W-1:0]       r_xrd;
    logic                  r_xwe;
    logic [4:0]            r_crd;
    logic                  r_cwe;

    // Result FIFO
    logic [X_ID_WIDTH-1:0] r_fifo_id   [FIFO_DEPTH];
    logic [31:0]           r_fifo_data [FIFO_DEPTH];
    logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
    logic                  r_fifo_we   [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_push;
    logic w_pop;
    logic w_load;

    // A full FIFO still takes the stage entry when the head leaves in the
    // same cycle, which keeps throughput at one operation per cycle.
    assign w_pop      = result_valid_o & result_ready_i;
    assign w_push     = r_valid & ((r_count < DEPTH_C) | w_pop);
    assign ex_ready_o = ~r_valid | w_push;
    assign w_load     = ex_valid_i & ex_ready_o;

    always_comb begin
        wb2regfile_o.write  = w_push & r_xwe;
        wb2regfile_o.rd     = r_xrd;
        wb2regfile_o.result = r_result;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_result <= '0;
            r_xrd    <= '0;
            r_xwe    <= 1'b0;
            r_crd    <= '0;
            r_cwe    <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_id     <= ex_id_i;
                r_result <= ex_result_i;
                r_xrd    <= ex_xrd_i;
                r_xwe    <= ex_xwe_i;
                r_crd    <= ex_crd_i;
                r_cwe    <= ex_cwe_i;
            end else if (w_push) begin
                r_valid  <= 1'b0;
            end
        end
    end

    // NOTE: the FIFO storage is reset because result_* are read straight from
    // the head slot and must be 0 out of reset; the array is only a few flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_id[i]   <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_rd[i]   <= '0;
                r_fifo_we[i]   <= 1'b0;
            end
        end else if (w_push) begin
            r_fifo_id[r_wr_ptr]   <= r_id;
            r_fifo_data[r_wr_ptr] <= r_cwe ? r_result : 32'd0;
            r_fifo_rd[r_wr_ptr]   <= r_crd;
            r_fifo_we[r_wr_ptr]   <= r_cwe;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign result_valid_o = (r_count != '0);
    assign result_id_o    = r_fifo_id[r_rd_ptr];
    assign result_data_o  = r_fifo_data[r_rd_ptr];
    assign result_rd_o    = r_fifo_rd[r_rd_ptr];
    assign result_we_o    = r_fifo_we[r_rd_ptr];

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Self-checking bench for fir_xifu_wb: a queue-based model of the stage slot
// and result FIFO predicts every output each cycle; directed steps add edge cases.
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] res;
        logic [1:0]  xrd;
        logic        xwe;
        logic [4:0]  crd;
        logic        cwe;
    } op_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 ex_valid_i;
    logic                 ex_ready_o;
    logic [3:0]           ex_id_i;
    logic [31:0]          ex_result_i;
    logic [1:0]           ex_xrd_i;
    logic                 ex_xwe_i;
    logic [4:0]           ex_crd_i;
    logic                 ex_cwe_i;
    fir_xifu_wb2regfile_t wb2regfile_o;
    logic                 result_valid_o;
    logic                 result_ready_i;
    logic [3:0]           result_id_o;
    logic [31:0]          result_data_o;
    logic [4:0]           result_rd_o;
    logic                 result_we_o;

    fir_xifu_wb #(.NB_REGS(4), .X_ID_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_id_i        (ex_id_i),
        .ex_result_i    (ex_result_i),
        .ex_xrd_i       (ex_xrd_i),
        .ex_xwe_i       (ex_xwe_i),
        .ex_crd_i       (ex_crd_i),
        .ex_cwe_i       (ex_cwe_i),
        .wb2regfile_o   (wb2regfile_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_data_o  (result_data_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o)
    );

    always #5 clk_i = ~clk_i;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    op_t         st_q[$];
    res_t        fq[$];
    op_t         pend[$];
    op_t         last_op;
    op_t         cur;
    bit          accepted;
    logic [31:0] shadow_rf [4];
    int          n_writes;
    int          n_popped;
    int          dut_stalls;
    int          max_fill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t to_res(input op_t o);
        res_t r;
        r.id   = o.id;
        r.data = o.cwe ? o.res : 32'd0;
        r.rd   = o.crd;
        r.we   = o.cwe;
        return r;
    endfunction

    function automatic op_t rand_op(input int id);
        op_t o;
        o.id  = 4'(id);
        o.res = $urandom;
        o.xrd = 2'($urandom_range(0, 3));
        o.xwe = 1'($urandom_range(0, 1));
        o.crd = 5'($urandom_range(0, 31));
        o.cwe = 1'($urandom_range(0, 1));
        return o;
    endfunction

    function automatic op_t zero_op();
        op_t o;
        o.id = '0; o.res = '0; o.xrd = '0; o.xwe = 1'b0; o.crd = '0; o.cwe = 1'b0;
        return o;
    endfunction

    // One clock cycle: inputs are already driven just after a negedge.
    task automatic cycle();
        logic m_pop, m_push, m_ready, m_we;
        res_t r;
        op_t  o;
        #1;
        m_pop   = (fq.size() != 0) && result_ready_i;
        m_push  = (st_q.size() != 0) && ((fq.size() < DEPTH) || m_pop);
        m_ready = (st_q.size() == 0) || m_push;
        m_we    = 1'b0;
        if (m_push) m_we = st_q[0].xwe;

        check("ex_ready", 32'(ex_ready_o), 32'(m_ready));
        check("rf_write", 32'(wb2regfile_o.write), 32'(m_we));
        check("rf_rd", 32'(wb2regfile_o.rd), 32'(last_op.xrd));
        check("rf_result", wb2regfile_o.result, last_op.res);
        check("res_valid", 32'(result_valid_o), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("res_id", 32'(result_id_o), 32'(fq[0].id));
            check("res_data", result_data_o, fq[0].data);
            check("res_rd", 32'(result_rd_o), 32'(fq[0].rd));
            check("res_we", 32'(result_we_o), 32'(fq[0].we));
        end

        if (wb2regfile_o.write === 1'b1) begin
            shadow_rf[wb2regfile_o.rd] = wb2regfile_o.result;
            n_writes++;
        end
        if (ex_valid_i && ex_ready_o !== 1'b1) dut_stalls++;

        if (m_pop) begin
            r = fq.pop_front();
            n_popped++;
        end
        if (m_push) begin
            o = st_q.pop_front();
            fq.push_back(to_res(o));
        end
        if (fq.size() > max_fill) max_fill = fq.size();
        accepted = ex_valid_i && m_ready;
        if (accepted) begin
            st_q.push_back(cur);
            last_op = cur;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_pending(input int budget, input bit toggle_ready, input bit must_finish);
        int n = 0;
        while (pend.size() != 0 && n < budget) begin
            cur         = pend[0];
            ex_valid_i  = 1'b1;
            ex_id_i     = cur.id;
            ex_result_i = cur.res;
            ex_xrd_i    = cur.xrd;
            ex_xwe_i    = cur.xwe;
            ex_crd_i    = cur.crd;
            ex_cwe_i    = cur.cwe;
            if (toggle_ready) result_ready_i = ~result_ready_i;
            cycle();
            if (accepted) void'(pend.pop_front());
            n++;
        end
        if (must_finish) check("drive_budget", 32'(pend.size()), 32'd0);
        if (must_finish) ex_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        ex_valid_i     = 1'b0;
        result_ready_i = 1'b1;
        while ((fq.size() != 0 || st_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_budget", 32'(fq.size() + st_q.size()), 32'd0);
    endtask

    initial begin
        int w0, p0;
        op_t o;

        rst_ni = 1'b0; ex_valid_i = 1'b0; result_ready_i = 1'b0;
        ex_id_i = '0; ex_result_i = '0; ex_xrd_i = '0; ex_xwe_i = 1'b0;
        ex_crd_i = '0; ex_cwe_i = 1'b0;
        last_op = zero_op(); cur = zero_op();
        for (int i = 0; i < 4; i++) shadow_rf[i] = '0;
        n_writes = 0; n_popped = 0; dut_stalls = 0; max_fill = 0;

        // Outputs while held in reset
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(ex_ready_o), 32'd1);
        check("rst_write", 32'(wb2regfile_o.write), 32'd0);
        check("rst_rf_result", wb2regfile_o.result, 32'd0);
        check("rst_valid", 32'(result_valid_o), 32'd0);
        check("rst_res_data", result_data_o, 32'd0);
        check("rst_res_id", 32'(result_id_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: idle after reset
        repeat (2) cycle();

        // 2: single operation, xwe only
        o.id = 4'd3; o.res = 32'hDEADBEEF; o.xrd = 2'd2; o.xwe = 1'b1; o.crd = 5'd0; o.cwe = 1'b0;
        pend.push_back(o);
        result_ready_i = 1'b1;
        drive_pending(4, 1'b0, 1'b1);
        drain(8);
        check("t2_reg2", shadow_rf[2], 32'hDEADBEEF);
        check("t2_writes", 32'(n_writes), 32'd1);

        // 3: back-pressure with four operations
        result_ready_i = 1'b0;
        w0 = n_writes; p0 = n_popped;
        for (int i = 0; i < 4; i++) begin
            o.id = 4'(i); o.res = 32'h10 + 32'(i); o.xrd = 2'(i); o.xwe = 1'b1;
            o.crd = 5'd5; o.cwe = 1'b1;
            pend.push_back(o);
        end
        drive_pending(5, 1'b0, 1'b0);
        check("t3_stall_ready", 32'(ex_ready_o), 32'd0);
        check("t3_stall_write", 32'(wb2regfile_o.write), 32'd0);
        check("t3_head_id", 32'(result_id_o), 32'd0);
        check("t3_pending", 32'(pend.size()), 32'd1);
        result_ready_i = 1'b1;
        drive_pending(8, 1'b0, 1'b1);
        drain(10);
        check("t3_writes", 32'(n_writes - w0), 32'd4);
        check("t3_results", 32'(n_popped - p0), 32'd4);
        check("t3_reg3", shadow_rf[3], 32'h13);

        // 4: ten operations back to back, no stall allowed
        result_ready_i = 1'b1;
        dut_stalls = 0; p0 = n_popped;
        for (int i = 0; i < 10; i++) pend.push_back(rand_op(i));
        drive_pending(10, 1'b0, 1'b1);
        check("t4_stalls", 32'(dut_stalls), 32'd0);
        drain(10);
        check("t4_results", 32'(n_popped - p0), 32'd10);

        // 5: continuous operations with ready toggling every cycle
        result_ready_i = 1'b0;
        max_fill = 0; p0 = n_popped;
        for (int i = 0; i < 24; i++) pend.push_back(rand_op(i % 16));
        drive_pending(100, 1'b1, 1'b1);
        drain(20);
        check("t5_max_fill", 32'(max_fill), 32'(DEPTH));
        check("t5_results", 32'(n_popped - p0), 32'd24);

        // 6: asynchronous reset with FIFO full and stage valid
        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) pend.push_back(rand_op(8 + i));
        for (int i = 0; i < 4; i++) pend[i].xwe = 1'b1;
        drive_pending(4, 1'b0, 1'b0);
        check("t6_pre_valid", 32'(result_valid_o), 32'd1);
        check("t6_pre_full", 32'(ex_ready_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", 32'(result_valid_o), 32'd0);
        check("t6_rst_write", 32'(wb2regfile_o.write), 32'd0);
        check("t6_rst_ready", 32'(ex_ready_o), 32'd1);
        st_q.delete(); fq.delete(); pend.delete();
        last_op = zero_op(); ex_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        p0 = n_popped;
        repeat (4) cycle();
        check("t6_no_stale", 32'(n_popped - p0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_xifu_wb.md
Name: fir_xifu_wb

Overview:
Writeback stage of the FIR XIFU. It accepts completed operations from EX and is the sole writer of the XIFU register file, driving the write port of fir_xifu_regfile. It also returns one CV-X-IF result per instruction to the core through a small result FIFO, so core back-pressure never corrupts regfile write ordering.

Parameters:
NB_REGS, 4, number of XIFU registers; rd field width is $clog2(NB_REGS).
X_ID_WIDTH, 4, CV-X-IF instruction id width.
FIFO_DEPTH, 2, result FIFO entries; power of two, at least 2.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
ex_valid_i  in  1  EX presents a completed operation.
ex_ready_o  out  1  WB accepts the operation.
ex_id_i  in  X_ID_WIDTH  instruction id.
ex_result_i  in  32  operation result.
ex_xrd_i  in  $clog2(NB_REGS)  XIFU destination register.
ex_xwe_i  in  1  write the result to the XIFU regfile.
ex_crd_i  in  5  core destination register.
ex_cwe_i  in  1  return the result to the core GPR.
wb2regfile_o  out  fir_xifu_wb2regfile_t  fields write, rd, result; sole write port of the regfile.
result_valid_o  in/out: out  1  CV-X-IF result valid.
result_ready_i  in  1  core accepts the result.
result_id_o  out  X_ID_WIDTH  result id.
result_data_o  out  32  result data; 0 when the core write is disabled.
result_rd_o  out  5  core destination register.
result_we_o  out  1  core GPR write enable.

Behaviour:
- Reset (async, active-low): the stage register is invalid, the FIFO is empty, and both pointers and the count are 0. All outputs are 0 except ex_ready_o, which is 1. Reset mid-operation drops every in-flight entry with no regfile write and no result.
- Stage register (one entry): it loads on ex_valid_i & ex_ready_o and captures id, result, xrd, xwe, crd and cwe.
- push = valid_q & (fifo_count < FIFO_DEPTH | pop). pop = result_valid_o & result_ready_i.
- ex_ready_o = ~valid_q | push. Full throughput is one operation per cycle. Back-to-back loads overwrite the stage register only in a cycle where push is asserted.
- Regfile write: wb2regfile_o.write = push & xwe_q, with rd = xrd_q and result = result_q.
  - The write is combinational and asserts for exactly one cycle per operation: the cycle the entry leaves the stage register.
  - While the FIFO is full and not popping, write stays 0 and the entry holds.
  - wb2regfile_o.rd and wb2regfile_o.result follow the stage register even when write is 0.
- FIFO entry on push: {id_q, cwe_q ? result_q : 0, crd_q, cwe_q}. Every operation produces exactly one result, including xwe-only operations, which produce a result with we=0.
- FIFO is in-order circular with wr_ptr and rd_ptr of width $clog2(FIFO_DEPTH). Both pointers wrap modulo FIFO_DEPTH.
- result_valid_o = (count != 0). result_* come from the head entry and stay stable while result_valid_o=1 and result_ready_i=0.
- Push into an empty FIFO has no bypass: the result becomes visible the next cycle.
- Push and pop in the same cycle when full: both happen, and the count stays FIFO_DEPTH.
- Push and pop in the same cycle when count is 1: both happen, the count stays 1, and the new entry is the head next cycle.
- Latency: EX handshake at cycle t, then the regfile write at t+1 (with no back-pressure), then result_valid_o at t+2.
- Ordering: regfile writes and results both follow EX acceptance order.

Test Plan:
1. After reset release with no stimulus, ex_ready_o=1, write=0 and result_valid_o=0.
2. Single operation: id=3, result=0xDEADBEEF, xrd=2, xwe=1, cwe=0, accepted at cycle 0.
   - Cycle 1: write=1, rd=2, result=0xDEADBEEF.
   - Cycle 2: result_valid_o=1, id=3, we=0, data=0, popped with ready=1.
   - Regfile reg2 reads 0xDEADBEEF.
3. Back-pressure: result_ready_i=0, with 4 operations ids 0..3 (xwe=1, cwe=1, crd=5, data=0x10+id).
   - Ids 0 and 1 fill the FIFO; id 2 holds in the stage register with write=0; ex_ready_o=0 with id 3 waiting.
   - Raise ready: results appear in order 0,1,2,3 with data 0x10..0x13.
   - Each regfile write occurs exactly once, in the cycle its entry is pushed.
4. Wrap-around: 10 operations at a continuous 1/cycle with result_ready_i=1.
   - No stall: ex_ready_o stays 1 and 10 results arrive in order.
   - Pointers wrap at least 4 times.
5. Simultaneous push and pop while full, with ready toggling every cycle:
   - The count never exceeds FIFO_DEPTH.
   - No result is lost or duplicated; a scoreboard checks ids and data.
6. Reset mid-operation with the FIFO holding 2 entries and the stage register valid:
   - Assert rst_ni=0 asynchronously.
   - result_valid_o and write drop to 0 immediately.
   - After release, no stale result appears.
